pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 32: width of the stage payload bus in bits.
REQ-002 SHALL have parameter DEPTH, default 2: number of payload entries; power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port flush_i, input, flush_pipeline_sig: FLUSH_PIPELINE discards all buffered and incoming entries.
REQ-006 SHALL have port invalidate_i, input, 1 bit: hazard bubble; the current incoming beat is dropped.
REQ-007 SHALL have port in_valid_i, input, 1 bit: upstream beat valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: buffer can accept a beat.
REQ-009 SHALL have port in_payload_i, input, PAYLOAD_W bits: upstream payload.
REQ-010 SHALL have port in_side_fx_i, input, 1 bit: per-beat side-effect request (e.g. memory read enable).
REQ-011 SHALL have port out_valid_o, output, 1 bit: head entry valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: downstream accepts the head entry.
REQ-013 SHALL have port out_payload_o, output, PAYLOAD_W bits: head entry payload.
REQ-014 SHALL have port out_side_fx_o, output, 1 bit: head side-effect bit ANDed with out_valid_o.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: number of occupied entries.
REQ-016 SHALL have ports stall_cycles_o and drop_count_o, output, 32 bits each: statistics counters (REQ-033).

Function
REQ-017 SHALL drive in_ready_o = (count_o < DEPTH), independent of out_ready_i (no combinational ready path).
REQ-018 SHALL define push = in_valid_i & in_ready_o & ~invalidate_i & (flush_i != FLUSH_PIPELINE).
REQ-019 SHALL define pop = out_valid_o & out_ready_i & (flush_i != FLUSH_PIPELINE).
REQ-020 SHALL drive out_valid_o = (count_o != 0); out_payload_o and side-effect bit come from the entry at the read pointer.
REQ-021 SHALL write a pushed beat into the entry at the write pointer; when empty, it appears at the outputs one cycle after the push.
REQ-022 SHALL advance the read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-023 SHALL leave count unchanged on simultaneous push and pop, including at count_o = DEPTH-1.
REQ-024 SHALL never push when full; a pop when full raises in_ready_o on the next cycle only.
REQ-025 SHALL, on flush, set count and both pointers to 0 on the next edge; a same-cycle push or pop has no effect.
REQ-026 SHALL, on invalidate_i without flush, drop the incoming beat and leave buffered entries and pop unaffected.
REQ-027 SHALL keep out_payload_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-028 SHALL force out_side_fx_o to 0 whenever out_valid_o = 0, whatever the storage contents.

Reset
REQ-029 SHALL, while reset_n_i = 0 at a rising edge, set count_o = 0, both pointers to 0, out_valid_o = 0, out_side_fx_o = 0, in_ready_o = 1 and both statistics counters to 0.
REQ-030 SHALL NOT reset payload storage; contents are don't-care while invalid.
REQ-031 SHALL give reset priority over flush, push and pop; a reset mid-transfer loses all buffered entries.

Configuration
REQ-032 SHALL compile statistics logic only when the macro PIPE_STAGE_STATS_EN is defined.
REQ-033 SHALL, with PIPE_STAGE_STATS_EN defined:
- increment stall_cycles_o each cycle with out_valid_o & ~out_ready_i;
- increment drop_count_o each cycle with in_valid_i & (invalidate_i | flush_i == FLUSH_PIPELINE);
- saturate both counters at 32'hFFFF_FFFF.
Without the macro, both ports SHALL be tied to 0 and contain no flops.

Structure
REQ-034 SHALL take flush_pipeline_sig and FLUSH_PIPELINE from the shared GENERAL_DEFS package; no new typedefs are local to the module.
REQ-035 SHALL place storage (DEPTH x (PAYLOAD_W+1) array, write port, read mux) in the sub-module pipe_stage_storage; pointers, count and stats remain in the parent.

Verification (DEPTH=4, PAYLOAD_W=32)
REQ-036 SHALL check reset: hold reset_n_i=0 for 2 cycles with in_valid_i=1 -> count_o=0, out_valid_o=0, in_ready_o=1.
REQ-037 SHALL check fill and drain: push 0x11,0x22,0x33,0x44 with out_ready_i=0 -> count_o=4, in_ready_o=0; then out_ready_i=1 -> outputs 0x11..0x44 in order on 4 consecutive cycles.
REQ-038 SHALL check wrap-around: 10 beats 0x0..0x9 streamed with in_valid_i=out_ready_i=1 -> outputs 0x0..0x9 in order, count_o stays 1, one cycle latency.
REQ-039 SHALL check flush: count_o=3 and push 0x55 with flush_i=FLUSH_PIPELINE -> next cycle count_o=0, out_valid_o=0, 0x55 never appears at the output.
REQ-040 SHALL check invalidate and side-effect gating: push 0xAA with invalidate_i=1 and in_side_fx_i=1 -> not stored, out_side_fx_o=0; push 0xBB with in_side_fx_i=1 -> out_side_fx_o=1 for that beat.
REQ-041 SHALL check stats with PIPE_STAGE_STATS_EN: 5 stall cycles plus 2 dropped beats -> stall_cycles_o=5, drop_count_o=2; without the macro -> both 0.

Source files
------------

// File: rtl/general_defs_pkg.sv
// Shared pipeline definitions: flush command encoding used by pipeline stages.
package general_defs_pkg;

  typedef enum logic {
    FLUSH_NONE     = 1'b0,
    FLUSH_PIPELINE = 1'b1
  } flush_pipeline_sig;

  localparam int unsigned STAT_W = 32;

endpackage : general_defs_pkg

// File: rtl/pipe_stage_storage.sv
// Payload plus side-effect storage for pipe_stage_buffer: one write port,
// one asynchronous read mux. Contents are not reset; validity lives in the parent.
module pipe_stage_storage #(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [PTR_W-1:0]     wr_addr_i,
  input  logic [PAYLOAD_W:0]   wr_data_i,
  input  logic [PTR_W-1:0]     rd_addr_i,
  output logic [PAYLOAD_W:0]   rd_data_o
);

  logic [PAYLOAD_W:0] mem [DEPTH];

  // write the pushed beat into the addressed entry
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule : pipe_stage_storage

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage buffer with flush and hazard-invalidate.
// Optional statistics counters are built only when PIPE_STAGE_STATS_EN is defined;
// otherwise stall_cycles_o and drop_count_o are constant 0.
module pipe_stage_buffer
  import general_defs_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  flush_pipeline_sig     flush_i,
  input  logic                  invalidate_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PAYLOAD_W-1:0]  in_payload_i,
  input  logic                  in_side_fx_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PAYLOAD_W-1:0]  out_payload_o,
  output logic                  out_side_fx_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [STAT_W-1:0]     stall_cycles_o,
  output logic [STAT_W-1:0]     drop_count_o
);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               flush_act;
  logic               push;
  logic               pop;
  logic [PAYLOAD_W:0] rd_data;

  assign flush_act   = (flush_i == FLUSH_PIPELINE);
  assign in_ready_o  = (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o & ~invalidate_i & ~flush_act;
  assign pop         = out_valid_o & out_ready_i & ~flush_act;
  assign count_o     = count;

  // pointers and occupancy; DEPTH is a power of two so pointer overflow wraps to 0
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  pipe_stage_storage #(
    .PAYLOAD_W (PAYLOAD_W),
    .DEPTH     (DEPTH)
  ) u_storage (
    .clk_i     (clk_i),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr),
    .wr_data_i ({in_side_fx_i, in_payload_i}),
    .rd_addr_i (rd_ptr),
    .rd_data_o (rd_data)
  );

  assign out_payload_o = rd_data[PAYLOAD_W-1:0];
  // stale storage must never issue a side effect
  assign out_side_fx_o = rd_data[PAYLOAD_W] & out_valid_o;

`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] drop_cnt;

  // saturating stall and drop counters
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (in_valid_i && (invalidate_i || flush_act) && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt;
  assign drop_count_o   = drop_cnt;
`else
  assign stall_cycles_o = '0;
  assign drop_count_o   = '0;
`endif

endmodule : pipe_stage_buffer

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer (DEPTH=4, PAYLOAD_W=32).
module tb_pipe_stage_buffer;
  import general_defs_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned DP = 4;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  flush_pipeline_sig flush_i;
  logic              invalidate_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PW-1:0]     in_payload_i;
  logic              in_side_fx_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PW-1:0]     out_payload_o;
  logic              out_side_fx_o;
  logic [2:0]        count_o;
  logic [31:0]       stall_cycles_o;
  logic [31:0]       drop_count_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_buffer #(.PAYLOAD_W(PW), .DEPTH(DP)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .flush_i        (flush_i),
    .invalidate_i   (invalidate_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_payload_i   (in_payload_i),
    .in_side_fx_i   (in_side_fx_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_payload_o  (out_payload_o),
    .out_side_fx_o  (out_side_fx_o),
    .count_o        (count_o),
    .stall_cycles_o (stall_cycles_o),
    .drop_count_o   (drop_count_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = FLUSH_NONE;
    invalidate_i = 1'b0;
    in_valid_i   = 1'b0;
    in_payload_i = '0;
    in_side_fx_i = 1'b0;
    out_ready_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_drop;

    idle_inputs();
    reset_n_i  = 1'b0;
    in_valid_i = 1'b1;
    in_payload_i = 32'hDEAD_BEEF;
    step();
    step();
    check_val("rst_count",  32'(count_o), 0);
    check_val("rst_ovalid", 32'(out_valid_o), 0);
    check_val("rst_iready", 32'(in_ready_o), 1);
    check_val("rst_sidefx", 32'(out_side_fx_o), 0);
    check_val("rst_stall",  stall_cycles_o, 0);
    check_val("rst_drop",   drop_count_o, 0);
    idle_inputs();
    reset_n_i = 1'b1;
    step();

    // fill with downstream stalled
    for (int i = 0; i < 4; i++) begin
      in_valid_i   = 1'b1;
      in_payload_i = 32'h11 * (i + 1);
      step();
      check_val("fill_head_stable", out_payload_o, 32'h11);
    end
    in_valid_i = 1'b0;
    check_val("full_count",  32'(count_o), 4);
    check_val("full_iready", 32'(in_ready_o), 0);

    // drain in order on consecutive cycles
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_valid", 32'(out_valid_o), 1);
      check_val("drain_data",  out_payload_o, 32'h11 * (i + 1));
      step();
      if (i == 0) check_val("ready_after_pop", 32'(in_ready_o), 1);
    end
    check_val("drain_empty", 32'(count_o), 0);

    // streaming with wrap-around of both pointers
    for (int i = 0; i < 10; i++) begin
      in_valid_i   = 1'b1;
      in_payload_i = 32'(i);
      out_ready_i  = 1'b1;
      step();
      check_val("wrap_count", 32'(count_o), 1);
      check_val("wrap_data",  out_payload_o, 32'(i));
    end
    in_valid_i = 1'b0;
    step();
    check_val("wrap_empty", 32'(count_o), 0);

    // flush with three buffered entries and a same-cycle push
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i   = 1'b1;
      in_payload_i = 32'h61 + 32'(i);
      step();
    end
    check_val("preflush_count", 32'(count_o), 3);
    in_payload_i = 32'h55;
    flush_i      = FLUSH_PIPELINE;
    out_ready_i  = 1'b1;
    step();
    check_val("flush_count",  32'(count_o), 0);
    check_val("flush_ovalid", 32'(out_valid_o), 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("flush_no_55", 32'(out_valid_o), 0);
    end

    // invalidate drops the beat; side effect gated by valid
    in_valid_i   = 1'b1;
    in_payload_i = 32'hAA;
    in_side_fx_i = 1'b1;
    invalidate_i = 1'b1;
    step();
    check_val("inv_count",  32'(count_o), 0);
    check_val("inv_sidefx", 32'(out_side_fx_o), 0);
    invalidate_i = 1'b0;
    in_payload_i = 32'hBB;
    step();
    in_valid_i = 1'b0;
    check_val("bb_data",   out_payload_o, 32'hBB);
    check_val("bb_sidefx", 32'(out_side_fx_o), 1);
    out_ready_i = 1'b1;
    step();
    check_val("bb_popped_sidefx", 32'(out_side_fx_o), 0);
    check_val("bb_popped_valid",  32'(out_valid_o), 0);

    // reset mid-transfer loses buffered entries
    idle_inputs();
    in_valid_i   = 1'b1;
    in_payload_i = 32'hC0;
    step();
    in_valid_i = 1'b0;
    reset_n_i  = 1'b0;
    step();
    check_val("midrst_count", 32'(count_o), 0);
    check_val("midrst_stall", stall_cycles_o, 0);

    // statistics: 5 stall cycles then 2 dropped beats
    reset_n_i    = 1'b1;
    in_valid_i   = 1'b1;
    in_payload_i = 32'h77;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    in_valid_i   = 1'b1;
    invalidate_i = 1'b1;
    out_ready_i  = 1'b1;
    step();
    step();
    idle_inputs();
    step();
`ifdef PIPE_STAGE_STATS_EN
    exp_stall = 32'd5;
    exp_drop  = 32'd2;
`else
    exp_stall = 32'd0;
    exp_drop  = 32'd0;
`endif
    check_val("stat_stall", stall_cycles_o, exp_stall);
    check_val("stat_drop",  drop_count_o, exp_drop);
    check_val("stat_empty", 32'(count_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_buffer
